// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and baud helper
// Purpose: parity codes, transmitter state encoding and the bit_period()
//          helper, kept here so the receiver can reuse them.
// Ports:   none (package).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Clocks per line bit. Integer division, so any remainder is dropped.
  function automatic int bit_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - valid/ready word stream into the UART transmitter
// Purpose: groups the upstream producer handshake.
// Ports:   s_data (word), s_valid (word valid), s_ready (transmitter accepts).
//          master = producer side, slave = transmitter side.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous word FIFO in front of the UART serialiser
// Purpose: buffers DEPTH words; the count and the ready flag are registered.
// Ports:   clk, reset (async, active-high), push_i/wdata_i (write side),
//          pop_i/rdata_o (read side; rdata_o shows the head word),
//          empty_o, ready_o (not full), count_o (words stored).
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  // Guard both sides so a misbehaving caller cannot corrupt the pointers.
  assign push    = push_i && ready_q;
  assign pop     = pop_i && (count_q != '0);
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (DATA_BITS, parity, stop bits)
// Purpose: serialises words from a valid/ready producer onto tx, LSB first,
//          with optional odd/even parity and 1 or 2 stop bits.
//          Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front.
// Ports:   clk, reset (async, active-high), s (uart_tx_cfg_if.slave),
//          tx (serial line, idle high), busy (frame on line),
//          frame_done (pulse in last clock of final stop bit),
//          fifo_count (buffered words; 0 without the FIFO).
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_tx_cfg_if.slave                  s,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUDRATE);
  localparam int CW         = (BIT_PERIOD < 2) ? 1 : $clog2(BIT_PERIOD);
  localparam int IW         = 4;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  if (BIT_PERIOD < 2) begin : g_bad_period
    $error("uart_tx_cfg: BIT_PERIOD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 load;
  logic [DATA_BITS-1:0] load_data;

`ifdef UART_TX_FIFO_EN
  logic                 fifo_empty;
  logic                 fifo_ready;
  logic [DATA_BITS-1:0] fifo_rdata;

  // Popping in IDLE loads the serialiser directly, so the start bit follows one clock later.
  assign load      = (state_q == ST_IDLE) && !fifo_empty;
  assign load_data = fifo_rdata;
  assign s.s_ready = fifo_ready;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s.s_valid),
    .wdata_i (s.s_data),
    .pop_i   (load),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .ready_o (fifo_ready),
    .count_o (fifo_count)
  );
`else
  logic ready_q;

  // Ready tracks the next state so it is already low in the start-bit clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= (state_d == ST_IDLE);
  end

  assign load       = s.s_valid && ready_q;
  assign load_data  = s.s_data;
  assign s.s_ready  = ready_q;
  assign fifo_count = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tx_d       = 1'b1;
    frame_done = 1'b0;
    bit_end    = (cnt_q == CNT_LAST);

    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_START;
          cnt_d   = '0;
          shreg_d = load_data;
          par_d   = (PARITY == PARITY_ODD) ? ~^load_data : ^load_data;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        // idx counts stop bits here.
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            frame_done = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is registered from the next state so tx never glitches.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int BP     = 10;

  logic clk;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

  wire  [3:0] tx_v, busy_v, fd_v, rdy_v;
  wire  [2:0] fc0, fc1, fc2, fc3;
  logic [3:0] val_v;
  logic [8:0] dat_v [4];

  assign if0.s_valid = val_v[0];
  assign if1.s_valid = val_v[1];
  assign if2.s_valid = val_v[2];
  assign if3.s_valid = val_v[3];
  assign if0.s_data  = dat_v[0][7:0];
  assign if1.s_data  = dat_v[1][7:0];
  assign if2.s_data  = dat_v[2][7:0];
  assign if3.s_data  = dat_v[3][6:0];
  assign rdy_v = {if3.s_ready, if2.s_ready, if1.s_ready, if0.s_ready};

  uart_tx_cfg #(.CLK_FREQ(CLK_HZ), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .s(if0), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]), .fifo_count(fc0));
  uart_tx_cfg #(.CLK_FREQ(CLK_HZ), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .s(if1), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]), .fifo_count(fc1));
  uart_tx_cfg #(.CLK_FREQ(CLK_HZ), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .s(if2), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]), .fifo_count(fc2));
  uart_tx_cfg #(.CLK_FREQ(CLK_HZ), .BAUDRATE(BAUD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .reset(reset), .s(if3), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(fd_v[3]), .fifo_count(fc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned just after a negedge; accept happens at the next usable posedge.
  task automatic send(input int i, input logic [8:0] w, input bit clobber);
    int n;
    n = 0;
    while (!rdy_v[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_send_ready", i), rdy_v[i], 1'b1);
    dat_v[i] = w;
    val_v[i] = 1'b1;
    @(posedge clk);
    #1;
    val_v[i] = 1'b0;
    if (clobber) dat_v[i] = '0;
`ifdef UART_TX_FIFO_EN
    @(posedge clk);
`endif
  endtask

  // Checks every clock of one frame, then the idle clock that follows it.
  task automatic check_frame(input int i, input logic [8:0] w, input int nb, input int par,
                             input int stops, input bit chk_rdy);
    logic exp_bits [16];
    logic p;
    int   n;
    p = 1'b0;
    for (int k = 0; k < nb; k++) p = p ^ w[k];
    exp_bits[0] = 1'b0;
    for (int k = 0; k < nb; k++) exp_bits[1+k] = w[k];
    n = 1 + nb;
    if (par == 1) begin exp_bits[n] = ~p; n++; end
    if (par == 2) begin exp_bits[n] = p;  n++; end
    for (int k = 0; k < stops; k++) begin exp_bits[n] = 1'b1; n++; end
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < BP; j++) begin
        @(negedge clk);
        chk($sformatf("u%0d_tx_bit%0d_clk%0d", i, b, j), tx_v[i], exp_bits[b]);
        chk($sformatf("u%0d_busy_bit%0d_clk%0d", i, b, j), busy_v[i], 1'b1);
        chk($sformatf("u%0d_done_bit%0d_clk%0d", i, b, j), fd_v[i], (b == n-1 && j == BP-1));
      end
    end
    @(negedge clk);
    chk($sformatf("u%0d_idle_busy", i), busy_v[i], 1'b0);
    chk($sformatf("u%0d_idle_tx", i), tx_v[i], 1'b1);
    chk($sformatf("u%0d_idle_done", i), fd_v[i], 1'b0);
    if (chk_rdy) chk($sformatf("u%0d_idle_ready", i), rdy_v[i], 1'b1);
  endtask

  initial begin
    val_v = '0;
    for (int i = 0; i < 4; i++) dat_v[i] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values on every instance.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_rst_tx", i), tx_v[i], 1'b1);
      chk($sformatf("u%0d_rst_busy", i), busy_v[i], 1'b0);
      chk($sformatf("u%0d_rst_done", i), fd_v[i], 1'b0);
      chk($sformatf("u%0d_rst_ready", i), rdy_v[i], 1'b0);
    end
    chk("u0_rst_fifo_count", fc0, 3'd0);
    chk("u3_rst_fifo_count", fc3, 3'd0);

    reset = 1'b0;
    #1;
    chk("ready_before_first_edge", rdy_v[0], 1'b0);

    // Idle after reset: line high, not busy, ready from the first clock.
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      chk($sformatf("idle_tx_%0d", c), tx_v[0], 1'b1);
      chk($sformatf("idle_busy_%0d", c), busy_v[0], 1'b0);
      chk($sformatf("idle_ready_%0d", c), rdy_v[0], 1'b1);
    end
    chk("idle_fifo_count", fc0, 3'd0);

    // 8N1 0xA5.
    send(0, 9'h0A5, 1'b0);
    check_frame(0, 9'h0A5, 8, 0, 1, 1'b1);

    // 8E1 and 8O1 0xA5: parity 0 and 1 respectively.
    send(1, 9'h0A5, 1'b0);
    check_frame(1, 9'h0A5, 8, 2, 1, 1'b1);
    send(2, 9'h0A5, 1'b0);
    check_frame(2, 9'h0A5, 8, 1, 1, 1'b1);

    // 7N2 0x7F with s_data cleared right after accept.
    send(3, 9'h07F, 1'b1);
    check_frame(3, 9'h07F, 7, 0, 2, 1'b1);

    // Reset 35 clocks into a frame (bit 2 of 0x5A is 0 at that point).
    send(0, 9'h05A, 1'b0);
    repeat (35) @(negedge clk);
    chk("abort_pre_tx", tx_v[0], 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_tx", tx_v[0], 1'b1);
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_ready", rdy_v[0], 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_done_%0d", c), fd_v[0], 1'b0);
      chk($sformatf("abort_hold_tx_%0d", c), tx_v[0], 1'b1);
    end
    reset = 1'b0;
    send(0, 9'h0C3, 1'b0);
    check_frame(0, 9'h0C3, 8, 0, 1, 1'b1);

    // Back-to-back frames with a single idle clock between them.
    send(0, 9'h001, 1'b0);
    check_frame(0, 9'h001, 8, 0, 1, 1'b1);
    send(0, 9'h080, 1'b0);
    check_frame(0, 9'h080, 8, 0, 1, 1'b1);
    send(0, 9'h0FF, 1'b0);
    check_frame(0, 9'h0FF, 8, 0, 1, 1'b1);
    chk("b2b_fifo_count", fc0, 3'd0);

`ifdef UART_TX_FIFO_EN
    begin
      logic [8:0] words [6];
      bit saw_full;
      words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033;
      words[3] = 9'h044; words[4] = 9'h055; words[5] = 9'h066;
      saw_full = 1'b0;
      fork
        begin
          for (int k = 0; k < 6; k++) begin
            int n;
            @(negedge clk);
            dat_v[0] = words[k];
            val_v[0] = 1'b1;
            n = 0;
            while (!rdy_v[0] && n < 500) begin
              if (!saw_full) begin
                chk("fifo_full_count", fc0, 3'd4);
                saw_full = 1'b1;
              end
              @(negedge clk);
              n++;
            end
            chk($sformatf("fifo_push_%0d", k), rdy_v[0], 1'b1);
            @(posedge clk);
          end
          @(negedge clk);
          val_v[0] = 1'b0;
        end
        begin
          int n;
          n = 0;
          do begin
            @(posedge clk);
            #1;
            n++;
          end while (!busy_v[0] && n < 100);
          chk("fifo_first_start", busy_v[0], 1'b1);
          for (int k = 0; k < 6; k++) check_frame(0, words[k], 8, 0, 1, 1'b0);
        end
      join
      chk("fifo_saw_full", saw_full, 1'b1);
      chk("fifo_drained", fc0, 3'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
